// File: rtl/game_cmd_encoder.sv
// game_cmd_encoder
//   Turns three raw pushbuttons into game commands for the game FSM.
//   Each button goes through a 2-flop synchronizer, a debounce down-counter
//   and a rising-edge detector. Press events are then arbitrated
//   (reset > pause > start), checked against the registered game state and
//   the busy flag, and issued as registered command outputs.
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset_n     asynchronous active-low reset
//   btn_start   raw start button, active-high, asynchronous
//   btn_pause   raw pause button, active-high, asynchronous
//   btn_reset   raw reset button, active-high, asynchronous
//   state_code  game state: 000 START, 001 PLAYING, 010 PAUSE, 011 RESET,
//               100 GAMEOVER, 101..111 invalid
//   startGame   one-cycle start command pulse
//   pauseGame   pause request level
//   resetGame   one-cycle game-reset command pulse
//   busy        high while an issued command awaits a state_code change
//   cmd_drop    one-cycle pulse when a press is ignored
//
// Command FSM states
//   state  | meaning
//   S_IDLE | no command outstanding, presses may be accepted
//   S_WAIT | command issued, waiting for state_code to move or timeout
module game_cmd_encoder #(
  parameter int DB_CYCLES   = 250000,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic [2:0] state_code,
  output logic       startGame,
  output logic       pauseGame,
  output logic       resetGame,
  output logic       busy,
  output logic       cmd_drop
);

  localparam int DBW = 20;
  localparam int ATW = 8;
  localparam logic [DBW-1:0] DB_LOAD  = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE   = DBW'(1);
  localparam logic [ATW-1:0] ACK_LOAD = ATW'(ACK_TIMEOUT);
  localparam logic [ATW-1:0] ACK_ONE  = ATW'(1);

  localparam int B_START = 0;
  localparam int B_PAUSE = 1;
  localparam int B_RESET = 2;

  typedef enum logic {S_IDLE, S_WAIT} cmd_state_t;

  logic [2:0]     btn_raw;
  logic [2:0]     sync1, sync2;
  logic [2:0]     db_lvl, db_dly;
  logic [2:0]     armed;
  logic [2:0]     press;
  logic [1:0]     warm;
  logic [DBW-1:0] db_left [3];

  cmd_state_t     state, state_nxt;
  logic [2:0]     sc_q, sc_lat, sc_lat_nxt;
  logic [ATW-1:0] ack_left, ack_left_nxt;
  logic           start_nxt, pause_nxt, reset_nxt, drop_nxt;
  logic           accept;
  logic           sc_run, sc_idle;

  assign btn_raw = {btn_reset, btn_pause, btn_start};

  // Button front end. db_left is a down-counter of remaining mismatch
  // cycles; zero means no mismatch run is in progress.
  // armed blocks press events until a button has been seen released after
  // reset (warm marks when sync2 first carries real input), so a button
  // held through reset must be let go and pressed again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      warm   <= '0;
      db_lvl <= '0;
      db_dly <= '0;
      armed  <= '0;
      press  <= '0;
      for (int i = 0; i < 3; i++) db_left[i] <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      warm   <= {warm[0], 1'b1};
      db_dly <= db_lvl;
      press  <= db_lvl & ~db_dly & armed;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_left[i] <= '0;
        end else if (db_left[i] == '0) begin
          if (DB_CYCLES == 1) db_lvl[i] <= ~db_lvl[i];
          else                db_left[i] <= DB_LOAD;
        end else if (db_left[i] == DB_ONE) begin
          db_lvl[i]  <= ~db_lvl[i];
          db_left[i] <= '0;
        end else begin
          db_left[i] <= db_left[i] - DB_ONE;
        end
        if (warm[1] && !sync2[i] && !db_lvl[i]) armed[i] <= 1'b1;
      end
    end
  end

  // state_code is updated by the game FSM on the falling edge, so it is
  // registered once before any decision uses it.
  assign sc_run  = (sc_q == 3'b001) || (sc_q == 3'b010);
  assign sc_idle = (sc_q == 3'b000) || (sc_q == 3'b011) || (sc_q == 3'b100);

  always_comb begin
    state_nxt    = state;
    sc_lat_nxt   = sc_lat;
    ack_left_nxt = ack_left;
    start_nxt    = 1'b0;
    reset_nxt    = 1'b0;
    drop_nxt     = 1'b0;
    pause_nxt    = pauseGame;
    accept       = 1'b0;

    // Only the highest-priority press is considered; the rest are dropped.
    if (press[B_RESET]) begin
      if (press[B_PAUSE] || press[B_START]) drop_nxt = 1'b1;
      if (state == S_IDLE && sc_run) begin
        reset_nxt = 1'b1;
        pause_nxt = 1'b0;
        accept    = 1'b1;
      end else begin
        drop_nxt = 1'b1;
      end
    end else if (press[B_PAUSE]) begin
      if (press[B_START]) drop_nxt = 1'b1;
      if (state == S_IDLE && sc_run) begin
        pause_nxt = ~pauseGame;
        accept    = 1'b1;
      end else begin
        drop_nxt = 1'b1;
      end
    end else if (press[B_START]) begin
      if (state == S_IDLE && sc_idle) begin
        start_nxt = 1'b1;
        accept    = 1'b1;
      end else begin
        drop_nxt = 1'b1;
      end
    end

    if (!sc_run) pause_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt    = S_WAIT;
          sc_lat_nxt   = sc_q;
          ack_left_nxt = ACK_LOAD;
        end
      end
      S_WAIT: begin
        // A timeout simply gives up; the command is not reissued.
        if (sc_q != sc_lat || ack_left == ACK_ONE) begin
          state_nxt    = S_IDLE;
          ack_left_nxt = '0;
        end else begin
          ack_left_nxt = ack_left - ACK_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sc_q      <= '0;
      sc_lat    <= '0;
      ack_left  <= '0;
      startGame <= 1'b0;
      pauseGame <= 1'b0;
      resetGame <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sc_q      <= state_code;
      sc_lat    <= sc_lat_nxt;
      ack_left  <= ack_left_nxt;
      startGame <= start_nxt;
      pauseGame <= pause_nxt;
      resetGame <= reset_nxt;
      cmd_drop  <= drop_nxt;
    end
  end

  assign busy = (state == S_WAIT);

endmodule

// File: tb/tb_game_cmd_encoder.sv
// tb_game_cmd_encoder
//   Directed bench for game_cmd_encoder with DB_CYCLES=4, ACK_TIMEOUT=15.
//   A table of single-press vectors plus hand-written sequences for latency,
//   bounce, timeout and reset-abort behaviour.
module tb_game_cmd_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start, btn_pause, btn_reset;
  logic [2:0] state_code;
  logic       startGame, pauseGame, resetGame, busy, cmd_drop;

  game_cmd_encoder #(.DB_CYCLES(4), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_reset  (btn_reset),
    .state_code (state_code),
    .startGame  (startGame),
    .pauseGame  (pauseGame),
    .resetGame  (resetGame),
    .busy       (busy),
    .cmd_drop   (cmd_drop)
  );

  always #5 clk = ~clk;

  // Running pulse totals, sampled on the falling edge.
  int tot_start = 0, tot_reset = 0, tot_drop = 0;
  always @(negedge clk) begin
    if (startGame) tot_start <= tot_start + 1;
    if (resetGame) tot_reset <= tot_reset + 1;
    if (cmd_drop)  tot_drop  <= tot_drop + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] sc;       // state_code during the press
    logic [2:0] btn;      // {reset, pause, start}
    int         e_start;
    int         e_reset;
    int         e_drop;
    logic       e_pause;
    logic       e_busy;
    logic [2:0] sc_next;  // state_code applied afterwards (ack or hold)
  } vec_t;

  vec_t vt[14];

  int s_start, s_reset, s_drop, n, nbusy;
  logic [11:0] bounce;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{3'b000, 3'b001, 1, 0, 0, 1'b0, 1'b1, 3'b001};
    vt[1]  = '{3'b001, 3'b001, 0, 0, 1, 1'b0, 1'b0, 3'b001};
    vt[2]  = '{3'b001, 3'b010, 0, 0, 0, 1'b1, 1'b1, 3'b010};
    vt[3]  = '{3'b010, 3'b010, 0, 0, 0, 1'b0, 1'b1, 3'b001};
    vt[4]  = '{3'b001, 3'b010, 0, 0, 0, 1'b1, 1'b1, 3'b010};
    vt[5]  = '{3'b010, 3'b100, 0, 1, 0, 1'b0, 1'b1, 3'b011};
    vt[6]  = '{3'b011, 3'b010, 0, 0, 1, 1'b0, 1'b0, 3'b011};
    vt[7]  = '{3'b011, 3'b001, 1, 0, 0, 1'b0, 1'b1, 3'b000};
    vt[8]  = '{3'b000, 3'b100, 0, 0, 1, 1'b0, 1'b0, 3'b000};
    vt[9]  = '{3'b001, 3'b110, 0, 1, 1, 1'b0, 1'b1, 3'b010};
    vt[10] = '{3'b010, 3'b011, 0, 0, 1, 1'b1, 1'b1, 3'b001};
    vt[11] = '{3'b101, 3'b001, 0, 0, 1, 1'b0, 1'b0, 3'b100};
    vt[12] = '{3'b100, 3'b001, 1, 0, 0, 1'b0, 1'b1, 3'b000};
    vt[13] = '{3'b100, 3'b111, 0, 0, 1, 1'b0, 1'b0, 3'b100};

    reset_n    = 1'b0;
    btn_start  = 1'b0;
    btn_pause  = 1'b0;
    btn_reset  = 1'b0;
    state_code = 3'b000;
    #3;
    chk("reset_outputs", int'({startGame, pauseGame, resetGame, busy, cmd_drop}), 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();

    // Clean start press: latency and pulse width, then ack by state change.
    s_start = tot_start;
    btn_start = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (startGame) break;
    end
    chk("start_latency", n, 8);
    tick();
    chk("start_width", int'(startGame), 0);
    chk("busy_after_start", int'(busy), 1);
    tick();
    btn_start = 1'b0;
    state_code = 3'b001;
    tick();
    chk("busy_before_ack", int'(busy), 1);
    tick();
    chk("busy_after_ack", int'(busy), 0);
    repeat (20) tick();
    chk("start_count", tot_start - s_start, 1);

    // Table of single-press vectors.
    for (int v = 0; v < 14; v++) begin
      state_code = vt[v].sc;
      repeat (3) tick();
      s_start = tot_start;
      s_reset = tot_reset;
      s_drop  = tot_drop;
      {btn_reset, btn_pause, btn_start} = vt[v].btn;
      repeat (10) tick();
      {btn_reset, btn_pause, btn_start} = 3'b000;
      repeat (2) tick();
      chk($sformatf("v%0d_pause", v), int'(pauseGame), int'(vt[v].e_pause));
      chk($sformatf("v%0d_busy", v), int'(busy), int'(vt[v].e_busy));
      state_code = vt[v].sc_next;
      repeat (25) tick();
      chk($sformatf("v%0d_start", v), tot_start - s_start, vt[v].e_start);
      chk($sformatf("v%0d_reset", v), tot_reset - s_reset, vt[v].e_reset);
      chk($sformatf("v%0d_drop", v), tot_drop - s_drop, vt[v].e_drop);
    end

    // Bouncing start in PLAYING: one debounced press, dropped once.
    state_code = 3'b001;
    repeat (3) tick();
    s_start = tot_start;
    s_drop  = tot_drop;
    bounce = 12'b1111_1111_0101;
    for (int c = 0; c < 12; c++) begin
      btn_start = bounce[c];
      tick();
    end
    btn_start = 1'b0;
    repeat (20) tick();
    chk("bounce_start", tot_start - s_start, 0);
    chk("bounce_drop", tot_drop - s_drop, 1);

    // Three stable cycles is one short of the debounce threshold.
    s_drop = tot_drop;
    btn_start = 1'b1;
    repeat (3) tick();
    btn_start = 1'b0;
    repeat (20) tick();
    chk("short_glitch_drop", tot_drop - s_drop, 0);

    // Exactly four stable cycles is enough.
    state_code = 3'b000;
    repeat (3) tick();
    s_start = tot_start;
    btn_start = 1'b1;
    repeat (4) tick();
    btn_start = 1'b0;
    repeat (12) tick();
    chk("exact_db_start", tot_start - s_start, 1);
    state_code = 3'b001;
    repeat (20) tick();

    // Timeout with state held at START; a second press while busy is dropped.
    state_code = 3'b000;
    repeat (3) tick();
    s_start = tot_start;
    s_drop  = tot_drop;
    nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      btn_start = (c <= 5) || (c >= 12 && c <= 19);
      tick();
      if (busy) nbusy++;
    end
    btn_start = 1'b0;
    chk("timeout_busy_cycles", nbusy, 15);
    chk("timeout_start", tot_start - s_start, 1);
    chk("busy_press_drop", tot_drop - s_drop, 1);
    repeat (10) tick();

    // Reset asserted while busy with pause set and a start mid-debounce.
    state_code = 3'b001;
    repeat (3) tick();
    s_start = tot_start;
    s_drop  = tot_drop;
    for (int c = 1; c <= 8; c++) begin
      btn_pause = (c <= 6);
      btn_start = (c >= 5);
      tick();
    end
    chk("pre_reset_pause", int'(pauseGame), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({startGame, pauseGame, resetGame, busy, cmd_drop}), 0);
    repeat (3) tick();
    state_code = 3'b000;
    reset_n = 1'b1;
    repeat (20) tick();
    chk("held_through_reset_start", tot_start - s_start, 0);
    chk("held_through_reset_drop", tot_drop - s_drop, 0);
    btn_start = 1'b0;
    repeat (10) tick();
    btn_start = 1'b1;
    repeat (6) tick();
    btn_start = 1'b0;
    repeat (10) tick();
    chk("repress_after_reset", tot_start - s_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
